// File: rtl/pellet_eat_sequencer.sv
// Pellet eat sequencer: once per frame reads the tile under Pac-Man,
// clears eaten pellets, keeps score, pellet count and the fright timer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for frame_tick; latches pac_addr on the tick
// S_READ  | address presented to tile RAM for one cycle
// S_WAIT  | covers the remaining READ_LAT-1 cycles of read latency
// S_CHECK | ram_rdata valid; pellet codes go to WRITE, others to IDLE
// S_WRITE | tile cleared, score/count/fright timer updated
module pellet_eat_sequencer #(
  parameter int ADDR_W        = 10,
  parameter int READ_LAT      = 2,
  parameter int TOTAL_PELLETS = 244,
  parameter int FRIGHT_FRAMES = 360,
  parameter int WARN_FRAMES   = 120,
  parameter int PELLET_PTS    = 10,
  parameter int POWER_PTS     = 50
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [ADDR_W-1:0] pac_addr,
  input  logic              level_restart,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [8:0]        ram_rdata,
  output logic [8:0]        ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic [15:0]       score,
  output logic [8:0]        pellets_left,
  output logic              frightened,
  output logic              fright_warn,
  output logic              level_clear
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam int WW = $clog2(READ_LAT + 1);
  localparam int TW = $clog2(FRIGHT_FRAMES + 1);

  localparam logic [8:0] TILE_PELLET = 9'h063;
  localparam logic [8:0] TILE_POWER  = 9'h062;
  localparam logic [8:0] TILE_EMPTY  = 9'h000;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [WW-1:0]     r_wait;
  logic              r_is_power;
  logic [15:0]       r_score;
  logic [8:0]        r_pellets;
  logic [TW-1:0]     r_timer;
  logic              r_level_clear;

  logic              w_commit;
  logic [16:0]       w_sum;

  // A write only takes effect if level_restart does not cancel it
  assign w_commit = (r_state == S_WRITE) && !level_restart;
  assign w_sum    = {1'b0, r_score} + (r_is_power ? 17'(POWER_PTS) : 17'(PELLET_PTS));

  // Sequencer FSM with read-latency down-counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wait     <= '0;
      r_is_power <= 1'b0;
    end else if (level_restart) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_addr  <= pac_addr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_wait  <= WW'(READ_LAT - 1);
          r_state <= (READ_LAT > 1) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          r_wait <= r_wait - 1'b1;
          if (r_wait <= WW'(1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_is_power <= (ram_rdata == TILE_POWER);
          if ((ram_rdata == TILE_PELLET) || (ram_rdata == TILE_POWER))
            r_state <= S_WRITE;
          else
            r_state <= S_IDLE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating score; kept across level_restart
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         r_score <= '0;
    else if (w_commit) r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  // Pellets-left counter with floor at zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                              r_pellets <= 9'(TOTAL_PELLETS);
    else if (level_restart)                 r_pellets <= 9'(TOTAL_PELLETS);
    else if (w_commit && r_pellets != 9'd0) r_pellets <= r_pellets - 1'b1;
  end

  // Fright timer: reload beats a coincident frame_tick decrement
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                               r_timer <= '0;
    else if (level_restart)                  r_timer <= '0;
    else if (w_commit && r_is_power)         r_timer <= TW'(FRIGHT_FRAMES);
    else if (frame_tick && r_timer != '0)    r_timer <= r_timer - 1'b1;
  end

  // Single-cycle pulse aligned with pellets_left first reading zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_level_clear <= 1'b0;
    else       r_level_clear <= w_commit && (r_pellets == 9'd1);
  end

  assign ram_addr     = r_addr;
  assign ram_wdata    = TILE_EMPTY;
  assign ram_we       = w_commit;
  assign busy         = (r_state != S_IDLE);
  assign score        = r_score;
  assign pellets_left = r_pellets;
  assign frightened   = (r_timer != '0);
  assign fright_warn  = (r_timer != '0) && (r_timer <= TW'(WARN_FRAMES));
  assign level_clear  = r_level_clear;

endmodule

// File: tb/tb_pellet_eat_sequencer.sv
// Scoreboard bench for pellet_eat_sequencer with a READ_LAT=2 tile RAM model.
module tb_pellet_eat_sequencer;
  localparam int TP = 244;
  localparam int FF = 360;
  localparam int WF = 120;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] pac_addr = '0;
  logic       level_restart = 1'b0;
  logic [9:0] ram_addr;
  logic [8:0] ram_rdata;
  logic [8:0] ram_wdata;
  logic       ram_we;
  logic       busy;
  logic [15:0] score;
  logic [8:0] pellets_left;
  logic       frightened;
  logic       fright_warn;
  logic       level_clear;

  pellet_eat_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pac_addr(pac_addr),
    .level_restart(level_restart), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .busy(busy), .score(score),
    .pellets_left(pellets_left), .frightened(frightened),
    .fright_warn(fright_warn), .level_clear(level_clear)
  );

  always #5 Clk = ~Clk;

  // Tile RAM: two-cycle registered read, write on ram_we, bench preload port
  logic [8:0] mem [0:1023];
  logic [8:0] rd_p0 = '0, rd_p1 = '0;
  logic       set_en = 1'b0;
  logic [9:0] set_addr = '0;
  logic [8:0] set_data = '0;
  always @(posedge Clk) begin
    rd_p0 <= mem[ram_addr];
    rd_p1 <= rd_p0;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (set_en) mem[set_addr] <= set_data;
  end
  assign ram_rdata = rd_p1;

  int n_checks = 0;
  int n_errors = 0;
  int lc_count = 0;
  int m_score, m_pellets, m_timer;

  typedef struct { logic [9:0] addr; int score; int pellets; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Count level_clear cycles
  always @(negedge Clk) if (level_clear === 1'b1) lc_count++;

  // Scoreboard consumer: every RAM write must match a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (ram_we === 1'b1) begin
        if (q.size() == 0) chk("unexpected_we", 32'(ram_we), 32'd0);
        else begin
          e = q.pop_front();
          chk("we_addr", 32'(ram_addr), 32'(e.addr));
          chk("we_wdata", 32'(ram_wdata), 32'd0);
          @(posedge Clk); #1;
          chk("wr_score", 32'(score), 32'(e.score));
          chk("wr_pellets", 32'(pellets_left), 32'(e.pellets));
        end
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'(m_score));
    chk({tag, "_pellets"}, 32'(pellets_left), 32'(m_pellets));
    chk({tag, "_fright"}, 32'(frightened), 32'(m_timer != 0));
    chk({tag, "_warn"}, 32'(fright_warn), 32'(m_timer != 0 && m_timer <= WF));
  endtask

  // One frame: preload tile, tick; race=extra tick in WRITE; abort 1=restart in WRITE, 2=Reset in WAIT
  task automatic eat_frame(input logic [9:0] a, input logic [8:0] code, input int race, input int abort);
    exp_t e;
    bit pel, pwr;
    pel = (code == 9'h063) || (code == 9'h062);
    pwr = (code == 9'h062);
    set_addr = a; set_data = code; set_en = 1'b1;
    @(posedge Clk); #1 set_en = 1'b0;
    pac_addr = a; frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0; pac_addr = ~a;
    if (m_timer > 0) m_timer--;
    if (abort == 2) begin
      @(posedge Clk); #1 Reset = 1'b1; #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_pellets", 32'(pellets_left), 32'(TP));
      chk("rst_fright", 32'(frightened), 32'd0);
      chk("rst_warn", 32'(fright_warn), 32'd0);
      chk("rst_lclear", 32'(level_clear), 32'd0);
      @(posedge Clk); #1 Reset = 1'b0;
      m_score = 0; m_pellets = TP; m_timer = 0;
      repeat (3) @(posedge Clk); #1;
      chk("rst_mem_kept", 32'(mem[a]), 32'(code));
      check_state("rst_after");
    end else begin
      if (pel && abort == 0) begin
        m_score = sat16(m_score + (pwr ? 50 : 10));
        if (m_pellets > 0) m_pellets--;
        e.addr = a; e.score = m_score; e.pellets = m_pellets;
        q.push_back(e);
      end
      repeat (3) @(posedge Clk); #1;
      if (race != 0) frame_tick = 1'b1;
      if (abort == 1) level_restart = 1'b1;
      @(posedge Clk); #1 frame_tick = 1'b0; level_restart = 1'b0;
      if (abort == 1) begin m_pellets = TP; m_timer = 0; end
      else if (pel && pwr) m_timer = FF;
      else if (race != 0 && m_timer > 0) m_timer--;
      @(posedge Clk); #1;
      check_state("frame");
      if (abort == 1) chk("restart_mem_kept", 32'(mem[a]), 32'(code));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) eat_frame(10'd0, 9'h000, 0, 0);
  endtask

  initial begin
    int lc0, s0;
    m_score = 0; m_pellets = TP; m_timer = 0;
    repeat (2) @(posedge Clk); #1;
    chk("reset_score", 32'(score), 32'd0);
    chk("reset_pellets", 32'(pellets_left), 32'(TP));
    chk("reset_we", 32'(ram_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_fright", 32'(frightened), 32'd0);
    Reset = 1'b0;
    set_addr = 10'd0; set_data = 9'h000; set_en = 1'b1;
    @(posedge Clk); #1 set_en = 1'b0;

    // Regular pellet
    eat_frame(10'h05A, 9'h063, 0, 0);
    chk("t1_score", 32'(score), 32'd10);
    chk("t1_pellets", 32'(pellets_left), 32'd243);
    chk("t1_mem_cleared", 32'(mem[10'h05A]), 32'd0);

    // Power pellet and fright expiry
    eat_frame(10'h123, 9'h062, 0, 0);
    chk("t2_score", 32'(score), 32'd60);
    chk("t2_fright", 32'(frightened), 32'd1);
    ticks(239);
    chk("t2_warn_239", 32'(fright_warn), 32'd0);
    ticks(1);
    chk("t2_warn_240", 32'(fright_warn), 32'd1);
    ticks(119);
    chk("t2_fright_359", 32'(frightened), 32'd1);
    ticks(1);
    chk("t2_fright_360", 32'(frightened), 32'd0);
    chk("t2_warn_360", 32'(fright_warn), 32'd0);

    // Reload coinciding with frame_tick, then a non-pellet tile
    eat_frame(10'h200, 9'h062, 0, 0);
    ticks(354);
    eat_frame(10'h201, 9'h062, 1, 0);
    s0 = m_score;
    eat_frame(10'h202, 9'h0A1, 0, 0);
    chk("t3_ignored_score", 32'(score), 32'(s0));
    chk("t3_ignored_mem", 32'(mem[10'h202]), 32'h0A1);
    ticks(238);
    chk("t3_warn_239", 32'(fright_warn), 32'd0);
    ticks(1);
    chk("t3_warn_240", 32'(fright_warn), 32'd1);

    // Eat every remaining pellet
    lc0 = lc_count;
    while (m_pellets > 0) eat_frame(10'($urandom_range(1, 1023)), 9'h063, 0, 0);
    chk("t4_pellets_zero", 32'(pellets_left), 32'd0);
    chk("t4_one_clear", 32'(lc_count - lc0), 32'd1);
    eat_frame(10'h044, 9'h063, 0, 0);
    chk("t4_floor", 32'(pellets_left), 32'd0);
    chk("t4_no_second_clear", 32'(lc_count - lc0), 32'd1);
    s0 = m_score;
    @(posedge Clk); #1 level_restart = 1'b1;
    @(posedge Clk); #1 level_restart = 1'b0;
    m_pellets = TP; m_timer = 0;
    chk("t4_restart_pellets", 32'(pellets_left), 32'(TP));
    chk("t4_restart_score", 32'(score), 32'(s0));

    // level_restart during WRITE discards the write
    eat_frame(10'h300, 9'h063, 0, 0);
    s0 = m_score;
    eat_frame(10'h301, 9'h062, 0, 1);
    chk("t6_restart_score", 32'(score), 32'(s0));
    chk("t6_restart_pellets", 32'(pellets_left), 32'(TP));
    chk("t6_restart_fright", 32'(frightened), 32'd0);

    // Saturation
    while (m_score <= 65530 - 50) eat_frame(10'($urandom_range(1, 1023)), 9'h062, 0, 0);
    while (m_score < 65530) eat_frame(10'($urandom_range(1, 1023)), 9'h063, 0, 0);
    chk("t5_score_65530", 32'(score), 32'd65530);
    eat_frame(10'h155, 9'h062, 0, 0);
    chk("t5_saturated", 32'(score), 32'hFFFF);
    eat_frame(10'h156, 9'h063, 0, 0);
    chk("t5_still_sat", 32'(score), 32'hFFFF);

    // Reset during WAIT
    eat_frame(10'h3F0, 9'h063, 0, 2);

    repeat (4) @(posedge Clk); #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
